dividend_rebuild: RTL and testbench

- Sequential shift-and-add block that runs the midterm divider in reverse: takes quotient, divisor and remainder and rebuilds the dividend as q*d + r.
- Sits beside the divider in the practice datapath as its checker/inverse; handshakes with start/busy/done.
- Multi-cycle: processes one quotient bit per clock, LSB first.
- Flags operand sets that no legal division could produce (d == 0, or r >= d) and flags results that overflow WIDTH bits.

---
 rtl/dividend_rebuild_pkg.sv | 20 ++
 rtl/dividend_rebuild_shift_add_step.sv | 30 +++
 rtl/dividend_rebuild.sv | 125 ++++++++++++
 tb/tb_dividend_rebuild.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dividend_rebuild_pkg.sv
// Shared definitions for the dividend rebuild block: default width,
// FSM state encodings and the bit-counter width helper.
`ifndef WIDTH
`define WIDTH 8
`endif

package dividend_rebuild_pkg;

  localparam int DR_WIDTH = `WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // A one-bit counter is still needed when WIDTH is 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/dividend_rebuild_shift_add_step.sv
// One shift-and-add step: adds d << idx when the quotient bit is set,
// plus the remainder on the final step.
module dividend_rebuild_shift_add_step
  import dividend_rebuild_pkg::*;
#(
  parameter int WIDTH = DR_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic [2*WIDTH:0] acc_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic             q_bit_i,
  input  logic             add_r_i,
  input  logic [WIDTH-1:0] r_i,
  output logic [2*WIDTH:0] acc_next_o
);

  logic [2*WIDTH:0] d_ext_s;
  logic [2*WIDTH:0] term_s;
  logic [2*WIDTH:0] r_term_s;

  // Operands are widened before shifting so nothing is lost off the top.
  always_comb begin
    d_ext_s    = {{(WIDTH+1){1'b0}}, d_i};
    term_s     = q_bit_i ? (d_ext_s << idx_i) : '0;
    r_term_s   = add_r_i ? {{(WIDTH+1){1'b0}}, r_i} : '0;
    acc_next_o = acc_i + term_s + r_term_s;
  end

endmodule

// File: rtl/dividend_rebuild.sv
// Rebuilds dividend = q*d + r one quotient bit per clock, LSB first, and
// flags illegal operand sets and results that overflow WIDTH bits.
`ifndef WIDTH
`define WIDTH 8
`endif

module dividend_rebuild
  import dividend_rebuild_pkg::*;
#(
  parameter int WIDTH = `WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             error
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] q_op_q;
  logic [WIDTH-1:0] d_op_q;
  logic [WIDTH-1:0] r_op_q;
  logic [2*WIDTH:0] acc_q;
  logic [2*WIDTH:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             error_q;
  logic             illegal_s;
  logic             last_s;

  // Operand legality and final-step detection.
  always_comb begin
    illegal_s = (d == '0) || (r >= d);
    last_s    = (cnt_q == LAST_IDX);
  end

  dividend_rebuild_shift_add_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step (
    .acc_i      (acc_q),
    .d_i        (d_op_q),
    .idx_i      (cnt_q),
    .q_bit_i    (q_op_q[cnt_q]),
    .add_r_i    (last_s),
    .r_i        (r_op_q),
    .acc_next_o (acc_d)
  );

  // Control FSM; the illegal path leaves acc at zero so FIN reports result 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      q_op_q     <= '0;
      d_op_q     <= '0;
      r_op_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            q_op_q     <= q;
            d_op_q     <= d;
            r_op_q     <= r;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            overflow_q <= 1'b0;
            error_q    <= illegal_s;
            state_q    <= illegal_s ? ST_FIN : ST_CALC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          if (last_s) begin
            state_q <= ST_FIN;
          end else begin
            cnt_q <= cnt_q + ONE_IDX;
          end
        end
        ST_FIN: begin
          result_q   <= acc_q[WIDTH-1:0];
          overflow_q <= |acc_q[2*WIDTH:WIDTH];
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;
  assign error    = error_q;

endmodule

// File: tb/tb_dividend_rebuild.sv
// Directed self-checking bench for dividend_rebuild (WIDTH = 8).
`timescale 1ns/1ps

module tb_dividend_rebuild;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] q;
  logic [7:0] d;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow;
  logic       error;

  int checks;
  int fails;

  dividend_rebuild #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .q        (q),
    .d        (d),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; q = 8'd0; d = 8'd0; r = 8'd0;
    step(); step();
    checks++;
    if ({busy, done, result, overflow, error} !== 12'h000) begin
      fails++;
      $display("FAIL reset: got busy=%b done=%b result=%0d ovf=%b err=%b, want all 0",
               busy, done, result, overflow, error);
    end
    rst_n = 1'b1;
    step();
  endtask

  // Legal operation: busy for edges k..k+8, done only after k+9.
  task automatic test_legal(input string name, input logic [7:0] qv, input logic [7:0] dv,
                            input logic [7:0] rv, input logic [7:0] exp_res, input logic exp_ovf);
    int bad;
    bad = 0;
    q = qv; d = dv; r = rv; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL %s_accept: got busy=%b err=%b ovf=%b, want 1 0 0", name, busy, error, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_busy: got %0d bad cycles, want 0", name, bad);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res || overflow !== exp_ovf || error !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: got done=%b busy=%b result=%0d ovf=%b err=%b, want 1 0 %0d %b 0",
               name, done, busy, result, overflow, error, exp_res, exp_ovf);
    end
    step();
    checks++;
    if (done !== 1'b0 || result !== exp_res || overflow !== exp_ovf) begin
      fails++;
      $display("FAIL %s_hold: got done=%b result=%0d ovf=%b, want 0 %0d %b",
               name, done, result, overflow, exp_res, exp_ovf);
    end
  endtask

  task automatic test_error(input string name, input logic [7:0] qv, input logic [7:0] dv,
                            input logic [7:0] rv);
    q = qv; d = dv; r = rv; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL %s_accept: got busy=%b done=%b err=%b ovf=%b, want 1 0 1 0",
               name, busy, done, error, overflow);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 8'd0 || overflow !== 1'b0 || error !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: got done=%b busy=%b result=%0d ovf=%b err=%b, want 1 0 0 0 1",
               name, done, busy, result, overflow, error);
    end
    step();
  endtask

  // Operands change and start stays high during CALC; second op starts only after done.
  task automatic test_ignore_start();
    int dones;
    dones = 0;
    q = 8'd10; d = 8'd4; r = 8'd1; start = 1'b1;
    step();
    q = 8'd255; d = 8'd255; r = 8'd0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ignore_calc: got dones=%0d busy=%b, want 0 1", dones, busy);
    end
    step();
    checks++;
    if (done !== 1'b1 || result !== 8'd41 || overflow !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL ignore_result: got done=%b result=%0d ovf=%b err=%b, want 1 41 0 0",
               done, result, overflow, error);
    end
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL ignore_reaccept: got busy=%b done=%b, want 1 0", busy, done);
    end
    repeat (8) step();
    step();
    checks++;
    if (done !== 1'b1 || result !== 8'h01 || overflow !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL max_operands: got done=%b result=%0d ovf=%b err=%b, want 1 1 1 0",
               done, result, overflow, error);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    q = 8'd9; d = 8'd9; r = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, overflow, error} !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b result=%0d ovf=%b err=%b, want all 0",
               busy, done, result, overflow, error);
    end
    step(); step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_nodone: got done=%b busy=%b, want 0 0", done, busy);
    end
    rst_n = 1'b1;
    step();
    test_legal("post_reset", 8'd2, 8'd7, 8'd6, 8'd20, 1'b0);
  endtask

  // start held high: done after edges k+9, k+19, k+29, k+39 only.
  task automatic test_back_to_back();
    int bad;
    int dones;
    bad = 0; dones = 0;
    q = 8'd0; d = 8'd1; r = 8'd0; start = 1'b1;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done === 1'b1) begin
        dones++;
        if (result !== 8'd0) bad++;
      end
      if (done !== ((i % 10) == 9)) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0 || dones != 4) begin
      fails++;
      $display("FAIL back_to_back: got %0d bad cycles and %0d dones, want 0 and 4", bad, dones);
    end
    repeat (12) step();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_legal("q5_d3_r2", 8'd5, 8'd3, 8'd2, 8'd17, 1'b0);
    test_legal("q0_d5_r4", 8'd0, 8'd5, 8'd4, 8'd4, 1'b0);
    test_ignore_start();
    test_error("err_d0", 8'd7, 8'd0, 8'd0);
    test_error("err_r_ge_d", 8'd4, 8'd3, 8'd3);
    test_legal("q200_d2_r1", 8'd200, 8'd2, 8'd1, 8'd145, 1'b1);
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
